alu_unit: RTL and testbench

- Registered integer ALU for the processor datapath, operating on unsigned operands of WIDTH+1 bits.
- Performs add, multiply, divide and subtract, selected by a 2-bit opcode.
- Produces a registered result plus zero and carry/borrow flags, one clock after the operands are presented.
- Feeds the writeback/flag logic of the execute stage.

---
 rtl/alu_unit.sv | 116 +++++++++++
 tb/tb_alu_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// Registered integer ALU for the execute stage. Operands are unsigned and
// WIDTH+1 bits wide. The result and flags appear one clock after the operands
// are presented.
//
// Ports:
//   clk     in   1        system clock, rising edge
//   rst     in   1        asynchronous active-high reset
//   a       in   WIDTH+1  operand A (unsigned)
//   b       in   WIDTH+1  operand B (unsigned)
//   opCode  in   2        00 add, 01 multiply, 10 divide, 11 subtract
//   ci      in   1        carry-in (add) / borrow-in (subtract)
//   out     out  WIDTH+1  registered result
//   cero    out  1        registered zero flag (out == 0)
//   cout    out  1        registered carry / borrow / overflow / div-by-zero
// -----------------------------------------------------------------------------
module alu_unit #(
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  input  logic [1:0]       opCode,
  input  logic             ci,
  output logic [WIDTH:0]   out,
  output logic             cero,
  output logic             cout
);

  localparam int DW = WIDTH + 1;
  localparam logic [DW-1:0] ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  // Restoring shift-subtract divider, fully unrolled into combinational logic.
  // The partial remainder carries one extra bit so the compare never overflows.
  function automatic logic [DW-1:0] div_restoring(input logic [DW-1:0] n,
                                                   input logic [DW-1:0] d);
    logic [DW:0]   rem;
    logic [DW-1:0] q;
    rem = {(DW+1){1'b0}};
    q   = ZERO;
    for (int i = DW - 1; i >= 0; i--) begin
      rem = {rem[DW-1:0], n[i]};
      if (rem >= {1'b0, d}) begin
        rem  = rem - {1'b0, d};
        q[i] = 1'b1;
      end else begin
        q[i] = 1'b0;
      end
    end
    return q;
  endfunction

  logic [DW:0]     sum_s;
  logic [DW:0]     diff_s;
  logic [2*DW-1:0] prod_s;
  logic [DW-1:0]   quot_s;
  logic [DW-1:0]   next_out_s;
  logic            next_cout_s;

  // One extra bit on sum/difference captures carry-out and borrow directly.
  assign sum_s  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
  assign diff_s = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, ci};
  assign prod_s = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign quot_s = div_restoring(a, b);

  // Select next result and flag from the opcode.
  always_comb begin
    next_out_s  = ZERO;
    next_cout_s = 1'b0;
    case (opCode)
      2'b00: begin
        next_out_s  = sum_s[DW-1:0];
        next_cout_s = sum_s[DW];
      end
      2'b01: begin
        next_out_s  = prod_s[DW-1:0];
        next_cout_s = |prod_s[2*DW-1:DW];
      end
      2'b10: begin
        if (b == ZERO) begin
          next_out_s  = ONES;
          next_cout_s = 1'b1;
        end else begin
          next_out_s  = quot_s;
          next_cout_s = 1'b0;
        end
      end
      2'b11: begin
        // Borrow shows up as the sign bit of the widened difference.
        next_out_s  = diff_s[DW-1:0];
        next_cout_s = diff_s[DW];
      end
      default: begin
        next_out_s  = ZERO;
        next_cout_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset forces a zero result with the zero flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= ZERO;
      cero <= 1'b1;
      cout <= 1'b0;
    end else begin
      out  <= next_out_s;
      cero <= (next_out_s == ZERO);
      cout <= next_cout_s;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  localparam int WIDTH = 23;
  localparam int DW    = WIDTH + 1;
  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [1:0]    op;
  logic          ci;
  logic [DW-1:0] out;
  logic          cero;
  logic          cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opCode(op), .ci(ci),
    .out(out), .cero(cero), .cout(cout)
  );

  task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  task automatic model(input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                       input logic [1:0] opi, input logic cii,
                       output logic [DW-1:0] eo, output logic ez, output logic ec);
    longint unsigned m, x, y, r;
    m = longint'(1) << DW;
    x = longint'(ai);
    y = longint'(bi);
    r = 0;
    ec = 1'b0;
    case (opi)
      2'b00: begin r = x + y + longint'(cii); ec = (r >= m); r = r % m; end
      2'b01: begin r = x * y; ec = (r >= m); r = r % m; end
      2'b10: begin
        if (y == 0) begin r = m - 1; ec = 1'b1; end
        else begin r = x / y; ec = 1'b0; end
      end
      default: begin
        ec = (x < y + longint'(cii));
        r  = (x + m - y - longint'(cii)) % m;
      end
    endcase
    eo = DW'(r);
    ez = (r == 0);
  endtask

  // Drive inputs, take one edge, sample just after it.
  task automatic apply(input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                       input logic [1:0] opi, input logic cii);
    a = ai; b = bi; op = opi; ci = cii;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                     input logic [1:0] opi, input logic cii,
                     input logic [DW-1:0] eo, input logic ez, input logic ec);
    apply(ai, bi, opi, cii);
    check_word({tag, ".out"}, out, eo);
    check_bit({tag, ".cero"}, cero, ez);
    check_bit({tag, ".cout"}, cout, ec);
  endtask

  initial begin
    logic [DW-1:0] ra, rb, eo;
    logic [1:0]    rop;
    logic          rci, ez, ec;
    int            sel;

    rst = 1'b1; a = '0; b = '0; op = 2'b00; ci = 1'b0;
    #3;
    check_word("reset.out", out, 24'h000000);
    check_bit("reset.cero", cero, 1'b1);
    check_bit("reset.cout", cout, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    dir("pre_rst_add", 24'd5, 24'd5, 2'b00, 1'b0, 24'd10, 1'b0, 1'b0);
    #3 rst = 1'b1;  // between edges
    #1;
    check_word("async_rst.out", out, 24'h000000);
    check_bit("async_rst.cero", cero, 1'b1);
    check_bit("async_rst.cout", cout, 1'b0);
    #2 rst = 1'b0;
    dir("post_rst_add", 24'd5, 24'd5, 2'b00, 1'b0, 24'd10, 1'b0, 1'b0);

    dir("s4_add", 24'd4, 24'd1, 2'b00, 1'b0, 24'd5, 1'b0, 1'b0);
    dir("s4_mul", 24'd4, 24'd1, 2'b01, 1'b0, 24'd4, 1'b0, 1'b0);
    dir("s4_div", 24'd4, 24'd1, 2'b10, 1'b0, 24'd4, 1'b0, 1'b0);
    dir("s4_sub", 24'd4, 24'd1, 2'b11, 1'b0, 24'd3, 1'b0, 1'b0);

    dir("s5_add", 24'd5, 24'd5, 2'b00, 1'b0, 24'd10, 1'b0, 1'b0);
    dir("s5_mul", 24'd5, 24'd5, 2'b01, 1'b0, 24'd25, 1'b0, 1'b0);
    dir("s5_div", 24'd5, 24'd5, 2'b10, 1'b0, 24'd1, 1'b0, 1'b0);
    dir("s5_sub", 24'd5, 24'd5, 2'b11, 1'b0, 24'd0, 1'b1, 1'b0);

    dir("add_wrap", ALL1, 24'd0, 2'b00, 1'b1, 24'd0, 1'b1, 1'b1);
    dir("sub_borrow", 24'd0, 24'd1, 2'b11, 1'b0, ALL1, 1'b0, 1'b1);
    dir("sub_borrow_ci", 24'd5, 24'd5, 2'b11, 1'b1, ALL1, 1'b0, 1'b1);
    dir("mul_ovf", 24'h001000, 24'h001000, 2'b01, 1'b0, 24'd0, 1'b1, 1'b1);
    dir("div_by0", 24'd7, 24'd0, 2'b10, 1'b0, ALL1, 1'b0, 1'b1);
    dir("div_small", 24'd3, 24'd7, 2'b10, 1'b0, 24'd0, 1'b1, 1'b0);
    dir("div_ones", ALL1, 24'd1, 2'b10, 1'b0, ALL1, 1'b0, 1'b0);
    dir("div_ci_ign", 24'd100, 24'd7, 2'b10, 1'b1, 24'd14, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      sel = int'($urandom_range(0, 7));
      ra  = (sel == 7) ? ALL1 : DW'($urandom);
      case (sel)
        0:       rb = 24'd0;
        1:       rb = DW'($urandom_range(1, 15));
        2:       rb = ra;
        default: rb = DW'($urandom);
      endcase
      if (sel == 3) ra = DW'($urandom_range(0, 4095));
      if (sel == 3) rb = DW'($urandom_range(0, 4095));
      rop = 2'($urandom);
      rci = 1'($urandom);
      model(ra, rb, rop, rci, eo, ez, ec);
      apply(ra, rb, rop, rci);
      check_word("rand.out", out, eo);
      check_bit("rand.cero", cero, ez);
      check_bit("rand.cout", cout, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
